// File: rtl/ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control FSM.
package ctrl_pkg;

    localparam int unsigned OPCODE_W    = 7;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned ALUOP_W_DEF = 3;
    localparam int unsigned TIMEOUT_DEF = 16;

    localparam logic [OPCODE_W-1:0] OP_R_TYPE   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_I_TYPE   = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_I_L_TYPE = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_S_TYPE   = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_B_TYPE   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_LUI      = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_AUIPC    = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_JAL      = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR     = 7'b1100111;

    localparam logic [2:0] ALUOP_ADD    = 3'b000;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_R      = 3'b010;
    localparam logic [2:0] ALUOP_I      = 3'b011;
    localparam logic [2:0] ALUOP_LUI    = 3'b100;
    localparam logic [2:0] ALUOP_AUIPC  = 3'b101;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; anything unrecognised is ILLEGAL.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0] i_OPCode,
    output iclass_t             o_class_c
);

    always_comb begin
        o_class_c = CLS_ILLEGAL;
        case (i_OPCode)
            OP_R_TYPE:   o_class_c = CLS_R;
            OP_I_TYPE:   o_class_c = CLS_I;
            OP_I_L_TYPE: o_class_c = CLS_LOAD;
            OP_S_TYPE:   o_class_c = CLS_STORE;
            OP_B_TYPE:   o_class_c = CLS_BRANCH;
            OP_LUI:      o_class_c = CLS_LUI;
            OP_AUIPC:    o_class_c = CLS_AUIPC;
            OP_JAL:      o_class_c = CLS_JAL;
            OP_JALR:     o_class_c = CLS_JALR;
            default:     o_class_c = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main control: FETCH/DECODE/EXEC/MEM/WB with ready-based memory waits.
// Define MULTICYCLE_CTRL_TRAP_EN for a sticky TRAP state on illegal opcodes and bus timeouts.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W        = ALUOP_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [OPCODE_W-1:0] i_OPCode,
    input  logic                i_InstrReady,
    input  logic                i_MemReady,
    output logic                o_InstrReq,
    output logic                o_IRWrite,
    output logic                o_PCWrite,
    output logic                o_Branch,
    output logic                o_Jump,
    output logic                o_MemRead,
    output logic                o_MemWrite,
    output logic                o_MemToReg,
    output logic [ALUOP_W-1:0]  o_ALUOp,
    output logic                o_ALUSrc1,
    output logic                o_ALUSrc2,
    output logic                o_RegWrite,
    output logic                o_Trap,
    output logic [STATE_W-1:0]  o_State
);

    localparam int unsigned      CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    iclass_t          class_q, class_d;
    iclass_t          dec_class;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             waiting;
    logic [2:0]       alu_op;

    ctrl_decode u_decode (
        .i_OPCode  (i_OPCode),
        .o_class_c (dec_class)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            class_q <= CLS_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Moore strobes; IRWrite/store PCWrite also qualify on the ready handshake.
    always_comb begin
        state_d    = state_q;
        class_d    = class_q;
        waiting    = 1'b0;
        alu_op     = ALUOP_ADD;
        o_InstrReq = 1'b0;
        o_IRWrite  = 1'b0;
        o_PCWrite  = 1'b0;
        o_Branch   = 1'b0;
        o_Jump     = 1'b0;
        o_MemRead  = 1'b0;
        o_MemWrite = 1'b0;
        o_MemToReg = 1'b0;
        o_ALUSrc1  = 1'b0;
        o_ALUSrc2  = 1'b0;
        o_RegWrite = 1'b0;
        o_Trap     = 1'b0;

        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                o_InstrReq = 1'b1;
                o_IRWrite  = i_InstrReady;
                if (i_InstrReady) state_d = DECODE;
                else              waiting = 1'b1;
            end
            DECODE: begin
                class_d = dec_class;
                state_d = EXEC;
`ifdef MULTICYCLE_CTRL_TRAP_EN
                if (dec_class == CLS_ILLEGAL) state_d = TRAP;
`endif
            end
            EXEC: begin
                state_d = WB;
                case (class_q)
                    CLS_R: alu_op = ALUOP_R;
                    CLS_I, CLS_JALR: begin
                        alu_op    = ALUOP_I;
                        o_ALUSrc2 = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        o_ALUSrc2 = 1'b1;
                        state_d   = MEM;
                    end
                    CLS_BRANCH: begin
                        alu_op    = ALUOP_BRANCH;
                        o_Branch  = 1'b1;
                        o_PCWrite = 1'b1;
                        state_d   = FETCH;
                    end
                    CLS_LUI: begin
                        alu_op    = ALUOP_LUI;
                        o_ALUSrc2 = 1'b1;
                    end
                    CLS_AUIPC: begin
                        alu_op    = ALUOP_AUIPC;
                        o_ALUSrc1 = 1'b1;
                        o_ALUSrc2 = 1'b1;
                    end
                    // Without the trap option an illegal opcode simply retires as a NOP.
                    CLS_ILLEGAL: begin
                        o_PCWrite = 1'b1;
                        state_d   = FETCH;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                o_MemRead  = (class_q == CLS_LOAD);
                o_MemWrite = (class_q == CLS_STORE);
                if (i_MemReady) begin
                    o_PCWrite = (class_q != CLS_LOAD);
                    state_d   = (class_q == CLS_LOAD) ? WB : FETCH;
                end else begin
                    waiting = 1'b1;
                end
            end
            WB: begin
                o_RegWrite = 1'b1;
                o_PCWrite  = 1'b1;
                o_MemToReg = (class_q == CLS_LOAD);
                o_Jump     = (class_q == CLS_JAL) || (class_q == CLS_JALR);
                state_d    = FETCH;
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            TRAP: o_Trap = 1'b1;
`endif
            default: state_d = IDLE;
        endcase

`ifdef MULTICYCLE_CTRL_TRAP_EN
        if (waiting && (cnt_q == CNT_MAX)) state_d = TRAP;
`endif

        o_ALUOp = ALUOP_W'(alu_op);
    end

    // Wait counter restarts on every state change and saturates at the timeout.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)            cnt_d = '0;
        else if (waiting && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end

    assign o_State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed instruction table, a reset-in-MEM sequence and a random stream.
module tb_multicycle_control;

    localparam int T = 16;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                           S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    localparam logic [14:0] O_REQ = 15'h4000, O_IRW = 15'h2000, O_PCW = 15'h1000,
                            O_BR  = 15'h0800, O_JMP = 15'h0400, O_MRD = 15'h0200,
                            O_MWR = 15'h0100, O_M2R = 15'h0080, O_S1  = 15'h0008,
                            O_S2  = 15'h0004, O_RW  = 15'h0002, O_TRP = 15'h0001;

    typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_LUI, K_AUIPC, K_JAL, K_JALR, K_ILL} kind_t;

    typedef struct packed {
        logic [6:0]  op;
        logic        ir;
        logic        mr;
        logic [2:0]  st;
        logic [14:0] o;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        int         fw;
        int         mw;
        int         lat;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        instr_ready, mem_ready;
    logic        o_InstrReq, o_IRWrite, o_PCWrite, o_Branch, o_Jump;
    logic        o_MemRead, o_MemWrite, o_MemToReg;
    logic [2:0]  o_ALUOp;
    logic        o_ALUSrc1, o_ALUSrc2, o_RegWrite, o_Trap;
    logic [2:0]  o_State;
    logic [14:0] outs;

    int   tests = 0;
    int   fails = 0;
    cyc_t exp_q[$];
    dir_t tbl[14];
    logic [6:0] rnd_ops[9];

    always #5 clk = ~clk;

    multicycle_control dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_OPCode     (opcode),
        .i_InstrReady (instr_ready),
        .i_MemReady   (mem_ready),
        .o_InstrReq   (o_InstrReq),
        .o_IRWrite    (o_IRWrite),
        .o_PCWrite    (o_PCWrite),
        .o_Branch     (o_Branch),
        .o_Jump       (o_Jump),
        .o_MemRead    (o_MemRead),
        .o_MemWrite   (o_MemWrite),
        .o_MemToReg   (o_MemToReg),
        .o_ALUOp      (o_ALUOp),
        .o_ALUSrc1    (o_ALUSrc1),
        .o_ALUSrc2    (o_ALUSrc2),
        .o_RegWrite   (o_RegWrite),
        .o_Trap       (o_Trap),
        .o_State      (o_State)
    );

    assign outs = {o_InstrReq, o_IRWrite, o_PCWrite, o_Branch, o_Jump, o_MemRead, o_MemWrite,
                   o_MemToReg, o_ALUOp, o_ALUSrc1, o_ALUSrc2, o_RegWrite, o_Trap};

    function automatic kind_t kind_of(input logic [6:0] op);
        case (op)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LD;
            7'b0100011: return K_ST;
            7'b1100011: return K_BR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] junk();
        return 7'($urandom);
    endfunction

    function automatic logic [14:0] alu(input logic [2:0] a);
        return {8'd0, a, 4'd0};
    endfunction

    function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] op, input logic ir,
                                input logic mr, input logic [14:0] o);
        cyc_t c;
        c.st = st; c.op = op; c.ir = ir; c.mr = mr; c.o = o;
        return c;
    endfunction

    function automatic void push(input logic [2:0] st, input logic [6:0] op, input logic ir,
                                 input logic mr, input logic [14:0] o);
        exp_q.push_back(mk(st, op, ir, mr, o));
    endfunction

    function automatic void add_trap();
        for (int i = 0; i < 4; i++) push(S_TRAP, junk(), rb(), rb(), O_TRP);
    endfunction

    // Reference: expected per-cycle trace of one instruction from the architectural rules.
    task automatic build(input logic [6:0] op, input int fw, input int mw, output bit trapped);
        kind_t       k;
        logic [14:0] ex, m;
        k = kind_of(op);
        trapped = 1'b0;
        exp_q.delete();
        for (int i = 0; i < fw; i++) begin
            push(S_FETCH, junk(), 1'b0, rb(), O_REQ);
            if (TRAP_ON && i == T) begin add_trap(); trapped = 1'b1; return; end
        end
        push(S_FETCH, junk(), 1'b1, rb(), O_REQ | O_IRW);
        push(S_DECODE, op, rb(), rb(), 15'd0);
        if (k == K_ILL) begin
            if (TRAP_ON) begin add_trap(); trapped = 1'b1; end
            else push(S_EXEC, junk(), rb(), rb(), O_PCW);
            return;
        end
        case (k)
            K_R:         ex = alu(3'b010);
            K_I, K_JALR: ex = alu(3'b011) | O_S2;
            K_LD, K_ST:  ex = alu(3'b000) | O_S2;
            K_BR:        ex = alu(3'b001) | O_BR | O_PCW;
            K_LUI:       ex = alu(3'b100) | O_S2;
            K_AUIPC:     ex = alu(3'b101) | O_S1 | O_S2;
            default:     ex = alu(3'b000);
        endcase
        push(S_EXEC, junk(), rb(), rb(), ex);
        if (k == K_BR) return;
        if (k == K_LD || k == K_ST) begin
            m = (k == K_LD) ? O_MRD : O_MWR;
            for (int i = 0; i < mw; i++) begin
                push(S_MEM, junk(), rb(), 1'b0, m);
                if (TRAP_ON && i == T) begin add_trap(); trapped = 1'b1; return; end
            end
            push(S_MEM, junk(), rb(), 1'b1, (k == K_ST) ? (m | O_PCW) : m);
            if (k == K_ST) return;
        end
        push(S_WB, junk(), rb(), rb(), O_RW | O_PCW | ((k == K_LD) ? O_M2R : 15'd0) |
             ((k == K_JAL || k == K_JALR) ? O_JMP : 15'd0));
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after posedge, compare {state,strobes} at negedge.
    task automatic step(input cyc_t c, input string nm, inout int lat);
        opcode      = c.op;
        instr_ready = c.ir;
        mem_ready   = c.mr;
        @(negedge clk);
        check(nm, 32'({o_State, outs}), 32'({c.st, c.o}));
        if (o_State >= S_FETCH && o_State <= S_WB) lat++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        int d;
        d = 0;
        rst_n       = 1'b0;
        instr_ready = rb();
        mem_ready   = rb();
        opcode      = junk();
        @(posedge clk);
        #1;
        check({tag, "_rst"}, 32'({o_State, outs}), 32'd0);
        rst_n = 1'b1;
        step(mk(S_IDLE, junk(), rb(), rb(), 15'd0), {tag, "_idle"}, d);
    endtask

    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input string tag, output int lat);
        bit trapped;
        build(op, fw, mw, trapped);
        lat = 0;
        for (int i = 0; i < exp_q.size(); i++) step(exp_q[i], $sformatf("%s_c%0d", tag, i), lat);
        if (trapped) do_reset(tag);
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 19);
        if (r < 12) return r % 4;
        if (r < 18) return $urandom_range(4, 8);
        if (r == 18) return T;
        return T + 1 + $urandom_range(0, 2);
    endfunction

    initial begin : main
        int         lat;
        int         d;
        logic [6:0] op;
        int         fw, mw;

        rst_n = 1'b0; opcode = '0; instr_ready = 1'b0; mem_ready = 1'b0;
        do_reset("init");

        tbl[0]  = '{7'b0110011, 0, 0, 4};
        tbl[1]  = '{7'b0000011, 0, 3, 8};
        tbl[2]  = '{7'b0100011, 1, 2, 7};
        tbl[3]  = '{7'b1100011, 0, 0, 3};
        tbl[4]  = '{7'b1100111, 0, 0, 4};
        tbl[5]  = '{7'b1111111, 0, 0, TRAP_ON ? 2 : 3};
        tbl[6]  = '{7'b0110011, 20, 0, TRAP_ON ? 17 : 24};
        tbl[7]  = '{7'b0110011, 16, 0, 20};
        tbl[8]  = '{7'b0000011, 0, 16, 21};
        tbl[9]  = '{7'b0110111, 2, 0, 6};
        tbl[10] = '{7'b0010111, 0, 0, 4};
        tbl[11] = '{7'b1101111, 0, 0, 4};
        tbl[12] = '{7'b0010011, 0, 5, 4};
        tbl[13] = '{7'b0100011, 0, 20, TRAP_ON ? 20 : 24};

        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].op, tbl[i].fw, tbl[i].mw, $sformatf("dir%0d", i), lat);
            check($sformatf("dir%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Reset while a load is held in MEM: the access is dropped and IDLE follows.
        d = 0;
        step(mk(S_FETCH, junk(), 1'b1, 1'b0, O_REQ | O_IRW), "rmid_fetch", d);
        step(mk(S_DECODE, 7'b0000011, 1'b0, 1'b0, 15'd0), "rmid_decode", d);
        step(mk(S_EXEC, junk(), 1'b0, 1'b0, O_S2), "rmid_exec", d);
        step(mk(S_MEM, junk(), 1'b0, 1'b0, O_MRD), "rmid_mem0", d);
        step(mk(S_MEM, junk(), 1'b1, 1'b0, O_MRD), "rmid_mem1", d);
        rst_n = 1'b0;
        step(mk(S_MEM, junk(), 1'b0, 1'b1, O_MRD), "rmid_mem_rst", d);
        step(mk(S_IDLE, junk(), 1'b1, 1'b1, 15'd0), "rmid_idle", d);
        rst_n = 1'b1;
        step(mk(S_IDLE, junk(), 1'b1, 1'b1, 15'd0), "rmid_idle2", d);

        rnd_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0) op = junk();
            else                           op = rnd_ops[$urandom_range(0, 8)];
            fw = pick_wait();
            mw = pick_wait();
            run_instr(op, fw, mw, $sformatf("rnd%0d", n), lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
